fifo_seq_checker: RTL and testbench
===================================

FIFO_SEQ_CHECKER -- requirements
Module: fifo_seq_checker

Interface
REQ-001 Parameter: DW, default 20, width of FIFO read data and counter words.
REQ-002 Parameter: RD_LAT, default 1, cycles from fifo_re high to fifo_q valid; legal values 1 and 2 only.
REQ-003 Port: clk  input  1  single clock, rising edge; drives every register.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: en  input  1  enable for draining the FIFO.
REQ-006 Port: clr  input  1  synchronous clear of statistics and tracking state.
REQ-007 Port: fifo_empty  input  1  FIFO EMPTY flag.
REQ-008 Port: fifo_q  input  DW  FIFO read data, valid RD_LAT cycles after fifo_re.
REQ-009 Port: fifo_re  output  1  FIFO read enable.
REQ-010 Port: dout  output  DW  checked data word, registered.
REQ-011 Port: dout_vld  output  1  one-cycle strobe qualifying dout.
REQ-012 Port: word_cnt  output  16  words received since reset or clr, modulo 2^16.
REQ-013 Port: err_cnt  output  16  sequence mismatches, saturating at 0xFFFF.
REQ-014 Port: err  output  1  sticky flag, set on first mismatch.
REQ-015 Port: exp_cap  output  DW  expected value at the most recent mismatch.
REQ-016 Port: got_cap  output  DW  received value at the most recent mismatch.
REQ-017 Port: locked  output  1  high while state is TRACK.

Function
REQ-018 fifo_re shall be combinational: en & ~fifo_empty & ~rst.
REQ-019 A valid pipeline of RD_LAT stages shall shift fifo_re; fifo_q shall be sampled only in the cycle the last stage is 1 (call this "arrival").
REQ-020 On arrival, dout shall register fifo_q and dout_vld shall pulse high for exactly one cycle, i.e. dout_vld lags fifo_re by RD_LAT+1 cycles.
REQ-021 FSM states: IDLE (no reference) and TRACK (expected value held in register exp).
REQ-022 IDLE + arrival: exp <= fifo_q+1 (mod 2^DW), word_cnt increments, and the state goes to TRACK; no error check is applied to this word.
REQ-023 TRACK + arrival with fifo_q == exp: exp <= exp+1 and word_cnt increments.
REQ-024 TRACK + arrival with fifo_q != exp: word_cnt increments, err_cnt increments (holds at 0xFFFF), err is set, exp_cap <= exp, got_cap <= fifo_q, and exp <= fifo_q+1 (resynchronise); the state stays TRACK.
REQ-025 Wrap: in TRACK with exp = 2^DW-1, the next expected word shall be 0; 0 following all-ones shall not be an error.
REQ-026 Deasserting en shall stop new reads immediately, and words already in flight shall still arrive and be checked.
REQ-027 fifo_empty high shall suppress fifo_re only; the block shall not track the FIFO fill level.
REQ-028 clr high shall zero word_cnt, err_cnt, err, exp_cap and got_cap, set the state to IDLE, and leave the valid pipeline running.
REQ-029 clr coincident with arrival: clr wins, and the word is neither counted nor used as reference, but dout/dout_vld still present it.
REQ-030 In-flight words arriving after clr shall be treated per REQ-022.

Reset
REQ-031 With rst high at a clk edge, every register shall clear: state IDLE, valid pipeline 0, dout 0, dout_vld 0, word_cnt 0, err_cnt 0, err 0, exp_cap 0, got_cap 0, exp 0.
REQ-032 fifo_re shall be 0 while rst is high.
REQ-033 Reset mid-operation shall discard in-flight words, and no dout_vld shall follow a read issued before reset.
REQ-034 The first arrival after rst deasserts shall be handled per REQ-022.

Verification
REQ-035 RD_LAT=1, en=1, FIFO supplies 0x00010..0x0001F -> 16 dout_vld pulses each 2 cycles after its fifo_re, word_cnt=16, err_cnt=0, err=0, locked=1.
REQ-036 Stream 5,6,7,9,10 -> err_cnt=1, err=1, exp_cap=8, got_cap=9, word_cnt=5, and no error on 10.
REQ-037 Stream 0xFFFFE,0xFFFFF,0x00000,0x00001 -> err_cnt=0, word_cnt=4.
REQ-038 RD_LAT=2, en dropped the cycle after 3 reads issued -> fifo_re=0 immediately, 3 arrivals still checked, word_cnt=3.
REQ-039 clr asserted on the arrival of word 0x00020 within stream 0x1F,0x20,0x21 -> after clr: word_cnt=1 (0x21 only), state TRACK, exp=0x22, err_cnt=0.
REQ-040 rst pulsed while 2 reads are in flight (RD_LAT=2) -> no dout_vld afterwards, all outputs 0, and the next arrival relocks with err_cnt=0.

Source files
------------

// File: rtl/fifo_seq_checker.sv
// Drains a FIFO and checks that the words read form an incrementing sequence
// (mod 2^DW). The first word after reset/clear becomes the reference; every
// following word must equal the previous one plus one. Mismatches are counted
// and captured, and the checker resynchronises on the offending word.
//
// Ports:
//   clk, rst     - single rising-edge clock, synchronous active-high reset
//   en           - enable draining the FIFO
//   clr          - synchronous clear of statistics and tracking state
//   fifo_empty   - FIFO empty flag
//   fifo_q       - FIFO read data, valid RD_LAT cycles after fifo_re
//   fifo_re      - FIFO read enable (combinational)
//   dout         - last received word, registered
//   dout_vld     - one-cycle strobe qualifying dout
//   word_cnt     - words received since reset/clr, wraps at 2^16
//   err_cnt      - sequence mismatches, saturating at 0xFFFF
//   err          - sticky mismatch flag
//   exp_cap      - expected value at the most recent mismatch
//   got_cap      - received value at the most recent mismatch
//   locked       - high while a reference value is being tracked
module fifo_seq_checker #(
  parameter int unsigned DW     = 20,
  parameter int unsigned RD_LAT = 1  // 1 or 2 only
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_q,
  output logic          fifo_re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic [15:0]   word_cnt,
  output logic [15:0]   err_cnt,
  output logic          err,
  output logic [DW-1:0] exp_cap,
  output logic [DW-1:0] got_cap,
  output logic          locked
);

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  state_e              state_q, state_d;
  logic [RD_LAT-1:0]   vld_q;
  logic                arrival;
  logic                mismatch;
  logic [DW-1:0]       exp_q;
  logic [DW-1:0]       dout_q;
  logic                dout_vld_q;
  logic [15:0]         word_cnt_q;
  logic [15:0]         err_cnt_q;
  logic                err_q;
  logic [DW-1:0]       exp_cap_q;
  logic [DW-1:0]       got_cap_q;

  // Gating with rst keeps the FIFO untouched while the checker is in reset.
  assign fifo_re  = en & ~fifo_empty & ~rst;
  assign arrival  = vld_q[RD_LAT-1];
  assign mismatch = arrival && (state_q == StTrack) && (fifo_q != exp_q);

  // Read-valid pipeline: tracks which cycle fifo_q carries a requested word.
  // clr deliberately leaves it running so in-flight words still arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= fifo_re;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: clr wins over a coincident arrival.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StIdle;
    end else if (arrival) begin
      state_d = StTrack;
    end
  end

  // FSM outputs
  always_comb begin
    locked = (state_q == StTrack);
  end

  // Datapath and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
      exp_cap_q  <= '0;
      got_cap_q  <= '0;
    end else begin
      // dout presents every arrival, even one swallowed by clr.
      dout_vld_q <= arrival;
      if (arrival) begin
        dout_q <= fifo_q;
      end
      if (clr) begin
        word_cnt_q <= '0;
        err_cnt_q  <= '0;
        err_q      <= 1'b0;
        exp_cap_q  <= '0;
        got_cap_q  <= '0;
      end else if (arrival) begin
        word_cnt_q <= word_cnt_q + 16'd1;
        // Whether locking, matching (fifo_q == exp) or resynchronising, the
        // next expected word is always the received word plus one.
        exp_q      <= fifo_q + DW'(1);
        if (mismatch) begin
          if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
          err_q     <= 1'b1;
          exp_cap_q <= exp_q;
          got_cap_q <= fifo_q;
        end
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err      = err_q;
  assign exp_cap  = exp_cap_q;
  assign got_cap  = got_cap_q;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Bench for fifo_seq_checker: one instance per legal read latency, both fed by
// one FIFO model. Every read pushes the word and its issue cycle onto a
// scoreboard; each dout_vld pops it and checks data and latency.
module tb_fifo_seq_checker;

  localparam int DW = 20;
  localparam logic [DW-1:0] JUNK = 20'hA5C3E;

  logic          clk;
  logic          rst, en, clr1, clr2;
  logic          fifo_empty;
  logic [DW-1:0] fifo_q1 = JUNK;
  logic [DW-1:0] fifo_q2 = JUNK;
  logic          re1, re2, dv1, dv2, err1, err2, lk1, lk2;
  logic [DW-1:0] dout1, dout2, ecap1, ecap2, gcap1, gcap2;
  logic [15:0]   wc1, wc2, ec1, ec2;

  fifo_seq_checker #(.DW(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr1), .fifo_empty(fifo_empty), .fifo_q(fifo_q1),
    .fifo_re(re1), .dout(dout1), .dout_vld(dv1), .word_cnt(wc1), .err_cnt(ec1), .err(err1),
    .exp_cap(ecap1), .got_cap(gcap1), .locked(lk1)
  );

  fifo_seq_checker #(.DW(DW), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr2), .fifo_empty(fifo_empty), .fifo_q(fifo_q2),
    .fifo_re(re2), .dout(dout2), .dout_vld(dv2), .word_cnt(wc2), .err_cnt(ec2), .err(err2),
    .exp_cap(ecap2), .got_cap(gcap2), .locked(lk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO storage (written by the test) and scoreboard (filled on each read).
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] sb_data [1024];
  int            sb_cyc  [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int sb_wr = 0;
  int sb_base = 0;
  int sb_rd1 = 0;
  int sb_rd2 = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO model: data appears 1 cycle after a read on fifo_q1, 2 on fifo_q2;
  // junk otherwise so a sample outside the arrival cycle is visible.
  always @(posedge clk) begin
    if (rst) sb_base <= sb_wr;  // reads already issued are lost
    if (re1) begin
      fifo_q1        <= mem[rd_ptr];
      sb_data[sb_wr] <= mem[rd_ptr];
      sb_cyc[sb_wr]  <= cyc;
      sb_wr          <= sb_wr + 1;
      rd_ptr         <= rd_ptr + 1;
    end else begin
      fifo_q1 <= JUNK;
    end
    fifo_q2 <= fifo_q1;
    cyc     <= cyc + 1;
  end

  typedef struct packed {
    logic [15:0][DW-1:0] w;
    logic [4:0]          n;
    logic [15:0]         wc;
    logic [15:0]         ec;
    logic                er;
    logic [DW-1:0]       ecap;
    logic [DW-1:0]       gcap;
    logic                lk;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input int n, input logic [DW-1:0] a, b, c, d, e,
                              input int wc, ec, input logic er,
                              input logic [DW-1:0] ecap, gcap, input logic lk);
    vec_t v;
    v      = '0;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
    v.n    = 5'(n);
    v.wc   = 16'(wc);
    v.ec   = 16'(ec);
    v.er   = er;
    v.ecap = ecap;
    v.gcap = gcap;
    v.lk   = lk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic score(input string tag, input logic dv, input logic [DW-1:0] d,
                       input int lat, inout int rd);
    if (!dv) return;
    if (rd >= sb_wr) begin
      n_chk++;
      $display("FAIL %s_spurious: dout_vld=1 (dout=%0h), expected 0", tag, d);
    end else begin
      chk({tag, "_data"}, 32'(d), 32'(sb_data[rd]));
      chk({tag, "_lat"}, cyc - sb_cyc[rd], lat + 1);
      rd++;
    end
  endtask

  // One cycle: sample on the falling edge, check fifo_re and any dout_vld.
  task automatic tick();
    logic exp_re;
    @(negedge clk);
    exp_re = en & ~fifo_empty & ~rst;
    chk("fifo_re_1", 32'(re1), 32'(exp_re));
    chk("fifo_re_2", 32'(re2), 32'(exp_re));
    if (sb_rd1 < sb_base) sb_rd1 = sb_base;
    if (sb_rd2 < sb_base) sb_rd2 = sb_base;
    score("dut1", dv1, dout1, 1, sb_rd1);
    score("dut2", dv2, dout2, 2, sb_rd2);
  endtask

  task automatic wait_idle(input string tag, input bit need_empty);
    int k;
    k = 0;
    while (!((!need_empty || rd_ptr == wr_ptr) && sb_rd1 == sb_wr && sb_rd2 == sb_wr)
           && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) begin
      n_chk++;
      $display("FAIL %s_timeout: outstanding words %0d, expected 0", tag, sb_wr - sb_rd2);
    end
    tick();
    tick();
  endtask

  task automatic drain(input string tag);
    en = 1'b1;
    wait_idle(tag, 1'b1);
    en = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input int wc, ec, input logic er,
                             input logic [DW-1:0] ecap, gcap, input logic lk);
    chk({tag, "_wc1"}, 32'(wc1), 32'(wc));     chk({tag, "_wc2"}, 32'(wc2), 32'(wc));
    chk({tag, "_ec1"}, 32'(ec1), 32'(ec));     chk({tag, "_ec2"}, 32'(ec2), 32'(ec));
    chk({tag, "_err1"}, 32'(err1), 32'(er));   chk({tag, "_err2"}, 32'(err2), 32'(er));
    chk({tag, "_ecap1"}, 32'(ecap1), 32'(ecap)); chk({tag, "_ecap2"}, 32'(ecap2), 32'(ecap));
    chk({tag, "_gcap1"}, 32'(gcap1), 32'(gcap)); chk({tag, "_gcap2"}, 32'(gcap2), 32'(gcap));
    chk({tag, "_lock1"}, 32'(lk1), 32'(lk));   chk({tag, "_lock2"}, 32'(lk2), 32'(lk));
  endtask

  task automatic check_dout_zero(input string tag);
    chk({tag, "_dout1"}, 32'(dout1), 0); chk({tag, "_dout2"}, 32'(dout2), 0);
    chk({tag, "_dv1"}, 32'(dv1), 0);     chk({tag, "_dv2"}, 32'(dv2), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr1 = 1'b0; clr2 = 1'b0;

    tbl[0] = mk(16, 0, 0, 0, 0, 0, 16, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) tbl[0].w[i] = DW'(32'h10 + i);
    tbl[1] = mk(5, 5, 6, 7, 9, 10, 5, 1, 1, 8, 9, 1);
    tbl[2] = mk(4, 20'hFFFFE, 20'hFFFFF, 0, 1, 0, 4, 0, 0, 0, 0, 1);
    tbl[3] = mk(1, 20'h123, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[4] = mk(3, 3, 3, 3, 0, 0, 3, 2, 1, 4, 3, 1);
    tbl[5] = mk(4, 100, 50, 51, 7, 0, 4, 2, 1, 52, 7, 1);

    tick(); tick(); tick();
    check_state("reset", 0, 0, 0, 0, 0, 0);
    check_dout_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < int'(tbl[r].n); i++) load(tbl[r].w[i]);
      drain($sformatf("vec%0d", r));
      check_state($sformatf("vec%0d", r), int'(tbl[r].wc), int'(tbl[r].ec), tbl[r].er,
                  tbl[r].ecap, tbl[r].gcap, tbl[r].lk);
    end

    // en dropped after three reads: reads stop at once, in-flight words land.
    do_reset();
    for (int i = 0; i < 10; i++) load(DW'(32'h40 + i));
    en = 1'b1;
    tick(); tick(); tick();
    en = 1'b0;
    #1;
    chk("en_drop_re1", 32'(re1), 0);
    chk("en_drop_re2", 32'(re2), 0);
    wait_idle("en_drop", 1'b0);
    check_state("en_drop", 3, 0, 0, 0, 0, 1);
    drain("en_drop_rest");
    check_state("en_drop_rest", 10, 0, 0, 0, 0, 1);

    // clr coincident with the arrival of 0x20 in each instance.
    do_reset();
    load(20'h1F); load(20'h20); load(20'h21);
    en = 1'b1;
    tick(); tick();
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0; clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    wait_idle("clr_arr", 1'b1);
    en = 1'b0;
    check_state("clr_arr", 1, 0, 0, 0, 0, 1);
    load(20'h50);  // exposes the expected value (0x22) through exp_cap
    drain("clr_probe");
    check_state("clr_probe", 2, 1, 1, 20'h22, 20'h50, 1);

    // Reset while two reads are in flight in the RD_LAT=2 instance.
    do_reset();
    load(20'h70); load(20'h71); load(20'h72);
    en = 1'b1;
    tick(); tick();
    rst = 1'b1;  // en stays high with data waiting: fifo_re must still be 0
    #1;
    chk("rst_re1", 32'(re1), 0);
    chk("rst_re2", 32'(re2), 0);
    tick();
    rst = 1'b0; en = 1'b0;
    check_state("rst_flight", 0, 0, 0, 0, 0, 0);
    check_dout_zero("rst_flight");
    repeat (5) tick();
    load(20'h73);
    drain("relock");
    check_state("relock", 2, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
